// File: rtl/min_os_pkg.sv
// Shared definitions for the text echo path.
// Holds the mode encodings, the ASCII case constants and a case-fold helper.
package min_os_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO    = 2'd0,
    MODE_UPPER   = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_REVERSE = 2'd3
  } mode_e;

  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= ASCII_LC_A && c <= ASCII_LC_Z) ? c - ASCII_CASE_OFS : c;
  endfunction

endpackage

// File: rtl/text_frame_xform.sv
// Combinational byte transform applied to a frame at capture.
// Ports: in_bytes (raw frame, byte 0 in [7:0]), size (already clamped length),
//        mode (echo/upper/count/reverse), out_bytes (transformed frame with
//        every byte at index >= size forced to 0x00).
module text_frame_xform
  import min_os_pkg::*;
#(
  parameter int MAX_BYTES = 32,
  parameter int SIZE_W    = 8
) (
  input  logic [MAX_BYTES*8-1:0] in_bytes,
  input  logic [SIZE_W-1:0]      size,
  input  mode_e                  mode,
  output logic [MAX_BYTES*8-1:0] out_bytes
);

  always_comb begin
    out_bytes = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      logic [7:0] b;
      b = '0;
      if (i < int'(size)) begin
        // Reverse reads from the mirrored index within the live length.
        if (mode == MODE_REVERSE) b = in_bytes[(int'(size)-1-i)*8 +: 8];
        else                      b = in_bytes[i*8 +: 8];
        if (mode == MODE_UPPER)   b = to_upper(b);
      end
      out_bytes[i*8 +: 8] = b;
    end
  end

endmodule

// File: rtl/text_echo_fifo.sv
// Text frame echo FIFO between the UART OS receive side and a transmitter.
// Ports: CLK/RST_N (clock, async active-low reset); rx_text_bytes/size and
//        rx_is_text_ready (received frame and its ready level); mode (sampled
//        at capture); tx_text_bytes/size, tx_valid, tx_ready (head frame and
//        handshake); byte_count (accepted bytes mod 256); level (stored
//        frames); overflow (sticky drop flag); view_index/view_byte (head
//        byte view_index+1 for LEDs).
module text_echo_fifo
  import min_os_pkg::*;
#(
  parameter int MAX_BYTES = 32,
  parameter int DEPTH     = 4,
  parameter int SIZE_W    = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [MAX_BYTES*8-1:0]    rx_text_bytes,
  input  logic [SIZE_W-1:0]         rx_text_size,
  input  logic                      rx_is_text_ready,
  input  logic [1:0]                mode,
  output logic [MAX_BYTES*8-1:0]    tx_text_bytes,
  output logic [SIZE_W-1:0]         tx_text_size,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                byte_count,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic [1:0]                view_index,
  output logic [7:0]                view_byte
);

  localparam int BW = MAX_BYTES*8;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW+1;
  localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(MAX_BYTES);

  // Capture stage
  logic              rdy_q, armed, rise;
  logic [SIZE_W-1:0] size_c;
  logic [BW-1:0]     xf_bytes;
  logic              cap_vld, cap_store;
  logic [BW-1:0]     cap_bytes;
  logic [SIZE_W-1:0] cap_size;

  assign size_c = (rx_text_size > MAX_SZ) ? MAX_SZ : rx_text_size;
  // armed stays low after reset until the ready level has been seen low, so a
  // level already high at reset release never counts as a rising edge.
  assign rise   = rx_is_text_ready & ~rdy_q & armed;

  text_frame_xform #(.MAX_BYTES(MAX_BYTES), .SIZE_W(SIZE_W)) u_xform (
    .in_bytes (rx_text_bytes),
    .size     (size_c),
    .mode     (mode_e'(mode)),
    .out_bytes(xf_bytes)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q     <= 1'b0;
      armed     <= 1'b0;
      cap_vld   <= 1'b0;
      cap_store <= 1'b0;
      cap_bytes <= '0;
      cap_size  <= '0;
    end else begin
      rdy_q     <= rx_is_text_ready;
      armed     <= armed | ~rx_is_text_ready;
      cap_vld   <= rise && (size_c != '0);
      cap_store <= rise && (size_c != '0) && (mode_e'(mode) != MODE_COUNT);
      cap_bytes <= xf_bytes;
      cap_size  <= size_c;
    end
  end

  // Frame storage
  logic [DEPTH-1:0][BW-1:0]     mem;
  logic [DEPTH-1:0][SIZE_W-1:0] msz;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LW-1:0] level_n;
  logic          pop, full, wr, drop;
  logic [BW-1:0]     head_bytes_n;
  logic [SIZE_W-1:0] head_size_n;
  logic [7:0]        view_n;

  assign pop  = tx_valid & tx_ready;
  assign full = (level == LW'(DEPTH));
  // A pop on the same cycle frees the slot, so a full FIFO still accepts.
  assign wr   = cap_store & (~full | pop);
  assign drop = cap_store & full & ~pop;

  always_comb begin
    wr_ptr_n     = wr  ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_n     = pop ? rd_ptr + PW'(1) : rd_ptr;
    level_n      = level + LW'(wr) - LW'(pop);
    head_bytes_n = '0;
    head_size_n  = '0;
    view_n       = '0;
    if (level_n != '0) begin
      // Entry being written this cycle becomes head when it lands at rd_ptr_n.
      if (wr && rd_ptr_n == wr_ptr) begin
        head_bytes_n = cap_bytes;
        head_size_n  = cap_size;
      end else begin
        head_bytes_n = mem[rd_ptr_n];
        head_size_n  = msz[rd_ptr_n];
      end
      view_n = head_bytes_n[(int'(view_index)+1)*8 +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem           <= '0;
      msz           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      tx_valid      <= 1'b0;
      tx_text_bytes <= '0;
      tx_text_size  <= '0;
      view_byte     <= '0;
      byte_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= cap_bytes;
        msz[wr_ptr] <= cap_size;
      end
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      level         <= level_n;
      tx_valid      <= (level_n != '0);
      tx_text_bytes <= head_bytes_n;
      tx_text_size  <= head_size_n;
      view_byte     <= view_n;
      if (cap_vld) byte_count <= byte_count + 8'(cap_size);
      if (drop)    overflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_echo_fifo.sv
module tb_text_echo_fifo;
  localparam int MB = 32;
  localparam int D  = 4;
  localparam int SW = 8;
  localparam int BW = MB*8;
  localparam int LW = $clog2(D)+1;
  typedef logic [BW-1:0] frame_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [BW-1:0] rx_text_bytes = '0;
  logic [SW-1:0] rx_text_size = '0;
  logic rx_is_text_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [BW-1:0] tx_text_bytes;
  logic [SW-1:0] tx_text_size;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [7:0] byte_count;
  logic [LW-1:0] level;
  logic overflow;
  logic [1:0] view_index = 2'd0;
  logic [7:0] view_byte;

  text_echo_fifo #(.MAX_BYTES(MB), .DEPTH(D), .SIZE_W(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx_text_bytes(rx_text_bytes), .rx_text_size(rx_text_size),
    .rx_is_text_ready(rx_is_text_ready), .mode(mode), .tx_text_bytes(tx_text_bytes),
    .tx_text_size(tx_text_size), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .byte_count(byte_count), .level(level), .overflow(overflow),
    .view_index(view_index), .view_byte(view_byte));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of stored frames plus counters
  frame_t mq[$];
  int     ms[$];
  int     m_cnt = 0;
  bit     m_ovf = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < MB; i++)
      f[i*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom);
    return f;
  endfunction

  // Frame as the spec defines it: clamp, optional reverse, optional upper-case.
  task automatic model_frame(input frame_t din, input int size, input int md,
                             output frame_t dout, output int sz);
    logic [7:0] src [MB];
    logic [7:0] c;
    for (int i = 0; i < MB; i++) src[i] = din[i*8 +: 8];
    sz   = (size > MB) ? MB : size;
    dout = '0;
    for (int i = 0; i < sz; i++) begin
      c = (md == 3) ? src[sz-1-i] : src[i];
      if (md == 1 && c >= "a" && c <= "z") c = c - 8'd32;
      dout[i*8 +: 8] = c;
    end
  endtask

  task automatic check_all(input string tag);
    frame_t hb;
    int     hs;
    hb = (mq.size() != 0) ? mq[0] : '0;
    hs = (mq.size() != 0) ? ms[0] : 0;
    chk({tag, "_vld"}, BW'(tx_valid), BW'(mq.size() != 0));
    chk({tag, "_lvl"}, BW'(level), BW'(mq.size()));
    chk({tag, "_size"}, BW'(tx_text_size), BW'(hs));
    chk({tag, "_bytes"}, tx_text_bytes, hb);
    chk({tag, "_view"}, BW'(view_byte), BW'(hb[(int'(view_index)+1)*8 +: 8]));
    chk({tag, "_cnt"}, BW'(byte_count), BW'(m_cnt % 256));
    chk({tag, "_ovf"}, BW'(overflow), BW'(m_ovf));
  endtask

  task automatic send(input frame_t d, input int size, input int md, input bit pop_same);
    frame_t e;
    int sz;
    bit was_vld;
    @(negedge CLK);
    rx_text_bytes = d; rx_text_size = SW'(size); mode = md[1:0];
    rx_is_text_ready = 1'b1; view_index = 2'($urandom_range(0, 3));
    was_vld = (mq.size() != 0);
    @(negedge CLK);
    chk("lat_pre", BW'(tx_valid), BW'(was_vld));
    rx_is_text_ready = 1'b0;
    if (pop_same) tx_ready = 1'b1;
    // Later mode/data changes must not affect the captured frame.
    mode = 2'($urandom); rx_text_bytes = rand_frame();
    @(negedge CLK);
    tx_ready = 1'b0;
    model_frame(d, size, md, e, sz);
    if (pop_same && was_vld) begin void'(mq.pop_front()); void'(ms.pop_front()); end
    if (sz != 0) begin
      m_cnt = (m_cnt + sz) % 256;
      if (md != 2) begin
        if (mq.size() < D) begin mq.push_back(e); ms.push_back(sz); end
        else m_ovf = 1'b1;
      end
    end
    check_all("send");
  endtask

  task automatic pop1();
    @(negedge CLK);
    tx_ready = 1'b1; view_index = 2'($urandom_range(0, 3));
    @(negedge CLK);
    tx_ready = 1'b0;
    if (mq.size() != 0) begin void'(mq.pop_front()); void'(ms.pop_front()); end
    check_all("pop");
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    mq.delete(); ms.delete(); m_cnt = 0; m_ovf = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    frame_t f;
    do_reset();
    @(negedge CLK);
    check_all("rst");

    // Echo "hi"
    f = '0; f[7:0] = 8'h68; f[15:8] = 8'h69;
    send(f, 2, 0, 0);
    chk("echo_hi", BW'(tx_text_bytes[15:0]), BW'(16'h6968));
    chk("echo_cnt", BW'(byte_count), BW'(2));
    pop1();

    // Upper-case and reverse
    f = '0; f[7:0] = "a"; f[15:8] = "Z"; f[23:16] = "1";
    send(f, 3, 1, 0);
    chk("upper", BW'(tx_text_bytes[23:0]), BW'(24'h315A41));
    pop1();
    f = '0; f[7:0] = "a"; f[15:8] = "b"; f[23:16] = "c";
    send(f, 3, 3, 0);
    chk("reverse", BW'(tx_text_bytes[23:0]), BW'(24'h616263));
    pop1();

    // Fill past full
    for (int i = 1; i <= 5; i++) begin f = '0; f[7:0] = 8'(i); send(f, 1, 0, 0); end
    chk("full_lvl", BW'(level), BW'(4));
    chk("full_ovf", BW'(overflow), BW'(1));
    for (int i = 1; i <= 4; i++) begin
      chk("full_order", BW'(tx_text_bytes[7:0]), BW'(i));
      pop1();
    end

    // Simultaneous capture and pop while full
    do_reset();
    for (int i = 0; i < 4; i++) send(rand_frame(), 1 + i, 0, 0);
    send(rand_frame(), 7, 1, 1);
    chk("simul_lvl", BW'(level), BW'(4));
    chk("simul_ovf", BW'(overflow), BW'(0));
    for (int i = 0; i < 4; i++) pop1();

    // Clamp and empty frame
    send(rand_frame(), 40, 0, 0);
    chk("clamp", BW'(tx_text_size), BW'(32));
    send(rand_frame(), 0, 0, 0);
    chk("size0", BW'(level), BW'(1));
    pop1();

    // 300 bytes counted only
    do_reset();
    for (int i = 0; i < 10; i++) send(rand_frame(), 30, 2, 0);
    chk("cnt300", BW'(byte_count), BW'(44));

    // Reset with frames stored and ready held high
    for (int i = 0; i < 3; i++) send(rand_frame(), 5, 0, 0);
    @(negedge CLK);
    rx_text_size = 8'd0; rx_is_text_ready = 1'b1;
    @(negedge CLK);
    rx_text_size = 8'd5; tx_ready = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    mq.delete(); ms.delete(); m_cnt = 0; m_ovf = 1'b0;
    chk("arst_lvl", BW'(level), BW'(0));
    chk("arst_vld", BW'(tx_valid), BW'(0));
    chk("arst_bytes", tx_text_bytes, '0);
    chk("arst_size", BW'(tx_text_size), BW'(0));
    chk("arst_cnt", BW'(byte_count), BW'(0));
    chk("arst_view", BW'(view_byte), BW'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    tx_ready = 1'b0;
    check_all("held_high");
    rx_is_text_ready = 1'b0;
    send(rand_frame(), 5, 0, 0);
    pop1();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 2) == 0) pop1();
      else send(rand_frame(), $urandom_range(0, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    while (mq.size() != 0) pop1();
    pop1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
